updown_counter_param: RTL and testbench

//  Parametrised up/down counter driven by an active-low push-button step input.

---
 rtl/udc_pkg.sv | 23 ++
 rtl/udc_step_gen.sv | 78 +++++++
 rtl/updown_counter_param.sv | 79 +++++++
 tb/tb_updown_counter_param.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/udc_pkg.sv
// Shared types and constants for the up/down counter slice.
// Optional wrap feature is selected with UDC_WRAP_EN.
package udc_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        PRESSED = 2'b01,
        REPEAT  = 2'b10
    } step_state_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Limit a value to the closed range [lo, hi].
    function automatic int unsigned clamp_val(input int unsigned v,
                                              input int unsigned lo,
                                              input int unsigned hi);
        if (v < lo)      return lo;
        else if (v > hi) return hi;
        else             return v;
    endfunction

endpackage

// File: rtl/udc_step_gen.sv
// Push-button step generator: 2-FF synchroniser, press FSM and hold/repeat timer.
// Emits a one-cycle step_pulse on press, after HOLD_CYCLES, then every REPEAT_CYCLES.
module udc_step_gen
    import udc_pkg::*;
#(
    parameter int HOLD_CYCLES   = 25000000,
    parameter int REPEAT_CYCLES = 5000000
) (
    input  logic clk,
    input  logic resetn,
    input  logic step_n,
    output logic step_pulse
);

    localparam int TMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] REP_LAST  = TW'(REPEAT_CYCLES - 1);

    logic [1:0]   sync_q;
    logic         pressed;
    step_state_t  state;
    logic [TW-1:0] timer;

    assign pressed = ~sync_q[1];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values and the simulation matches the synthesized flops.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            // Synchroniser resets to the released level so reset never fakes a press.
            sync_q     <= 2'b11;
            state      <= IDLE;
            timer      <= '0;
            step_pulse <= 1'b0;
        end else begin
            sync_q     <= {sync_q[0], step_n};
            step_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (pressed) begin
                        state      <= PRESSED;
                        step_pulse <= 1'b1;
                        timer      <= '0;
                    end
                end
                PRESSED: begin
                    if (!pressed) begin
                        state <= IDLE;
                        timer <= '0;
                    end else if (timer == HOLD_LAST) begin
                        state      <= REPEAT;
                        step_pulse <= 1'b1;
                        timer      <= '0;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                REPEAT: begin
                    if (!pressed) begin
                        state <= IDLE;
                        timer <= '0;
                    end else if (timer == REP_LAST) begin
                        step_pulse <= 1'b1;
                        timer      <= '0;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    timer <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/updown_counter_param.sv
// Bounded up/down counter stepped by a push-button with auto-repeat, clear and clamped load.
// Define UDC_WRAP_EN to add the wrap port (wrap-around instead of saturation when wrap=1).
module updown_counter_param
    import udc_pkg::*;
#(
    parameter int WIDTH         = 4,
    parameter int MIN_VAL       = 0,
    parameter int MAX_VAL       = 15,
    parameter int HOLD_CYCLES   = 25000000,
    parameter int REPEAT_CYCLES = 5000000
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             step_n,
    input  logic             up,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
`ifdef UDC_WRAP_EN
    input  logic             wrap,
`endif
    output logic [WIDTH-1:0] count,
    output logic             at_max,
    output logic             at_min,
    output logic             step_pulse
);

    localparam logic [WIDTH-1:0] MIN_C = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);

    logic             wrap_mode;
    logic [WIDTH-1:0] next_count;

`ifdef UDC_WRAP_EN
    assign wrap_mode = wrap;
`else
    assign wrap_mode = 1'b0;
`endif

    udc_step_gen #(
        .HOLD_CYCLES   (HOLD_CYCLES),
        .REPEAT_CYCLES (REPEAT_CYCLES)
    ) u_step_gen (
        .clk        (clk),
        .resetn     (resetn),
        .step_n     (step_n),
        .step_pulse (step_pulse)
    );

    // NOTE: next_count gets a default before any branch so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        next_count = count;
        if (clear) begin
            next_count = MIN_C;
        end else if (load) begin
            next_count = WIDTH'(clamp_val(32'(load_val), MIN_VAL, MAX_VAL));
        end else if (step_pulse) begin
            if (up == DIR_UP)
                next_count = (count >= MAX_C) ? (wrap_mode ? MIN_C : MAX_C) : count + WIDTH'(1);
            else
                next_count = (count <= MIN_C) ? (wrap_mode ? MAX_C : MIN_C) : count - WIDTH'(1);
        end
    end

    // Flags are computed from next_count so they change on the same edge as count.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            count  <= MIN_C;
            at_min <= 1'b1;
            at_max <= 1'b0;
        end else begin
            count  <= next_count;
            at_max <= (next_count == MAX_C);
            at_min <= (next_count == MIN_C);
        end
    end

endmodule

// File: tb/tb_updown_counter_param.sv
// Self-checking bench for updown_counter_param: directed scenarios plus random stimulus
// compared every cycle against a press-duration/arithmetic reference model.
module tb_updown_counter_param;

    localparam int WIDTH = 4;
    localparam int MIN_V = 2;
    localparam int MAX_V = 9;
    localparam int HOLD  = 4;
    localparam int REP   = 2;

    logic             clk = 1'b0;
    logic             resetn, step_n, up, clear, load, wrap;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic             at_max, at_min, step_pulse;

    int total = 0;
    int bad   = 0;
    int dut_pulses = 0;
    bit chk_en = 1'b0;

    // Reference model state
    int unsigned m_count = MIN_V;
    bit          m_pulse = 1'b0;
    bit          h0 = 1'b1, h1 = 1'b1;
    int          hold_len = 0;

    always #5 clk = ~clk;

    updown_counter_param #(
        .WIDTH(WIDTH), .MIN_VAL(MIN_V), .MAX_VAL(MAX_V),
        .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)
    ) dut (
        .clk(clk), .resetn(resetn), .step_n(step_n), .up(up),
        .clear(clear), .load(load), .load_val(load_val),
`ifdef UDC_WRAP_EN
        .wrap(wrap),
`endif
        .count(count), .at_max(at_max), .at_min(at_min), .step_pulse(step_pulse)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the button is seen two edges late; a press produces a step on its first
    // sampled cycle, again after HOLD cycles held, then every REP cycles.
    always @(posedge clk) begin
        bit pressed;
        bit wrap_eff;
`ifdef UDC_WRAP_EN
        wrap_eff = wrap;
`else
        wrap_eff = 1'b0;
`endif
        if (!resetn) begin
            m_count = MIN_V; m_pulse = 1'b0; h0 = 1'b1; h1 = 1'b1; hold_len = 0;
        end else begin
            if (clear)
                m_count = MIN_V;
            else if (load)
                m_count = (load_val < MIN_V) ? MIN_V : (load_val > MAX_V) ? MAX_V : load_val;
            else if (m_pulse) begin
                if (up) m_count = (m_count == MAX_V) ? (wrap_eff ? MIN_V : MAX_V) : m_count + 1;
                else    m_count = (m_count == MIN_V) ? (wrap_eff ? MAX_V : MIN_V) : m_count - 1;
            end
            pressed = !h1;
            h1 = h0;
            h0 = step_n;
            hold_len = pressed ? hold_len + 1 : 0;
            m_pulse = pressed && (hold_len == 1 ||
                      (hold_len >= HOLD + 1 && (hold_len - 1 - HOLD) % REP == 0));
        end
    end

    always @(negedge clk) begin
        if (step_pulse === 1'b1) dut_pulses++;
        if (chk_en) begin
            check("count",      32'(count),      m_count);
            check("at_max",     32'(at_max),     32'(m_count == MAX_V));
            check("at_min",     32'(at_min),     32'(m_count == MIN_V));
            check("step_pulse", 32'(step_pulse), 32'(m_pulse));
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int hold_n);
        step_n = 1'b0;
        cycles(hold_n);
        step_n = 1'b1;
        cycles(8);
    endtask

    task automatic do_load(input int v);
        load = 1'b1; load_val = WIDTH'(v);
        cycles(1);
        load = 1'b0;
    endtask

    initial begin
        int p0;
        resetn = 1'b0; step_n = 1'b1; up = 1'b1; clear = 1'b0;
        load = 1'b0; load_val = '0; wrap = 1'b0;
        cycles(2);
        chk_en = 1'b1;
        check("rst_count",  32'(count),      32'd2);
        check("rst_at_min", 32'(at_min),     32'd1);
        check("rst_at_max", 32'(at_max),     32'd0);
        check("rst_pulse",  32'(step_pulse), 32'd0);
        resetn = 1'b1;
        cycles(1);

        // 1: single short press
        p0 = dut_pulses;
        press(2);
        check("t1_pulses", dut_pulses - p0, 32'd1);
        check("t1_count",  32'(count),  32'd3);
        check("t1_at_min", 32'(at_min), 32'd0);

        // 2: load then two presses to saturate at the top
        do_load(8);
        check("t2_load", 32'(count), 32'd8);
        press(2);
        check("t2_count1", 32'(count),  32'd9);
        check("t2_at_max", 32'(at_max), 32'd1);
        press(2);
        check("t2_count2", 32'(count),  32'd9);

        // 3: held button with auto-repeat from MIN
        clear = 1'b1; cycles(1); clear = 1'b0;
        p0 = dut_pulses;
        press(10);
        check("t3_pulses", dut_pulses - p0, 32'd4);
        check("t3_count",  32'(count), 32'd6);

        // 4: clamped load and clear priority
        do_load(15);
        check("t4_clamp_hi", 32'(count), 32'd9);
        do_load(0);
        check("t4_clamp_lo", 32'(count), 32'd2);
        do_load(7);
        clear = 1'b1; load = 1'b1; load_val = 4'd7;
        cycles(1);
        clear = 1'b0; load = 1'b0;
        check("t4_clear_over_load", 32'(count), 32'd2);

`ifdef UDC_WRAP_EN
        // 5: wrap-around and saturation with wrap off
        do_load(9);
        wrap = 1'b1; up = 1'b1;
        press(2);
        check("t5_wrap_up", 32'(count), 32'd2);
        up = 1'b0;
        press(2);
        check("t5_wrap_down", 32'(count), 32'd9);
        wrap = 1'b0; up = 1'b1;
        press(2);
        check("t5_sat", 32'(count), 32'd9);
`endif

        // 6: reset during REPEAT, button still held
        up = 1'b1;
        clear = 1'b1; cycles(1); clear = 1'b0;
        step_n = 1'b0;
        cycles(9);
        resetn = 1'b0;
        cycles(1);
        check("t6_rst_count", 32'(count),      32'd2);
        check("t6_rst_pulse", 32'(step_pulse), 32'd0);
        resetn = 1'b1;
        cycles(4);
        check("t6_repress", 32'(count), 32'd3);
        step_n = 1'b1;
        cycles(8);

        // Random phase
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0)  step_n = ~step_n;
            if ($urandom_range(0, 7) == 0)  up = ~up;
            if ($urandom_range(0, 49) == 0) wrap = ~wrap;
            clear    = ($urandom_range(0, 39) == 0);
            load     = ($urandom_range(0, 29) == 0);
            load_val = WIDTH'($urandom_range(0, 15));
            resetn   = ($urandom_range(0, 299) != 0);
            cycles(1);
        end
        resetn = 1'b1; clear = 1'b0; load = 1'b0; step_n = 1'b1;
        cycles(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
